// File: rtl/izh_decoder_pkg.sv
// Shared constants and helpers for the Izhikevich spike decoder.
// Width defaults are picked up by the decoder top and its ISI FIFO.
package izh_decoder_pkg;

  localparam int unsigned CNT_W      = 16;
  localparam int unsigned RATE_W     = 8;
  localparam int unsigned WIN_W      = 16;
  localparam int unsigned FIFO_DEPTH = 4;

  // Saturating increment on values up to 32 bits; callers cast back to their width.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v, input logic [31:0] max_v);
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

// File: rtl/izh_spike_decoder_if.sv
// ISI readout port: head-of-FIFO interval with valid/ready handshake.
// The decoder drives the master side; the readout logic uses the slave side.
interface izh_spike_decoder_if #(
  parameter int unsigned CNT_W = 16
);

  logic [CNT_W-1:0] isi_data;
  logic             isi_valid;
  logic             isi_ready;

  modport master (
    output isi_data,
    output isi_valid,
    input  isi_ready
  );

  modport slave (
    input  isi_data,
    input  isi_valid,
    output isi_ready
  );

endinterface

// File: rtl/isi_fifo.sv
// Small synchronous FIFO for inter-spike intervals. Pointers carry a wrap bit
// so full and empty are told apart; a pop frees a slot for a same-cycle push.
module isi_fifo #(
  parameter int unsigned W     = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout_c,
  output logic         empty_c,
  output logic         drop_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          full_c;
  logic          do_pop_c;
  logic          do_push_c;

  assign empty_c   = (wr_ptr == rd_ptr);
  assign full_c    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop_c  = pop & ~empty_c;
  assign do_push_c = push & (~full_c | do_pop_c);
  assign drop_c    = push & full_c & ~do_pop_c;
  assign dout_c    = empty_c ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer update; flush empties the queue in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push_c) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop_c)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage: contents are never observed while empty, so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_push_c && !flush) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/izh_spike_decoder.sv
// Decodes a neuron spike level into inter-spike intervals (queued, valid/ready
// readout) and per-window spike rates with a one-cycle update strobe.
module izh_spike_decoder #(
  parameter int unsigned CNT_W      = izh_decoder_pkg::CNT_W,
  parameter int unsigned RATE_W     = izh_decoder_pkg::RATE_W,
  parameter int unsigned WIN_W      = izh_decoder_pkg::WIN_W,
  parameter int unsigned FIFO_DEPTH = izh_decoder_pkg::FIFO_DEPTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               clear,
  input  logic               spike_in,
  input  logic [WIN_W-1:0]   window_len,
  izh_spike_decoder_if.master isi,
  output logic [RATE_W-1:0]  rate_out,
  output logic               rate_stb,
  output logic               overflow
);

  import izh_decoder_pkg::sat_inc32;

  localparam logic [CNT_W-1:0]  T_MAX = '1;
  localparam logic [RATE_W-1:0] R_MAX = '1;

  logic              spike_q;
  logic              armed;
  logic [CNT_W-1:0]  t;
  logic              push_q;
  logic [CNT_W-1:0]  push_isi;
  logic [WIN_W-1:0]  win_cnt;
  logic [RATE_W-1:0] spk_cnt;

  logic              event_c;
  logic              last_c;
  logic [RATE_W-1:0] cnt_nxt_c;
  logic              pop_c;
  logic              fifo_empty_c;
  logic              drop_c;
  logic [CNT_W-1:0]  fifo_dout_c;

  assign event_c   = ena & spike_in & ~spike_q;
  assign last_c    = (win_cnt >= window_len - WIN_W'(1));
  assign cnt_nxt_c = event_c ? RATE_W'(sat_inc32(32'(spk_cnt), 32'(R_MAX))) : spk_cnt;
  assign pop_c     = isi.isi_ready & ~clear;

  // Edge detect: the spike level is sampled every cycle, enabled or not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) spike_q <= 1'b0;
    else        spike_q <= spike_in;
  end

  // ISI timer and arming; each armed event stages its interval for the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t        <= '0;
      armed    <= 1'b0;
      push_q   <= 1'b0;
      push_isi <= '0;
    end else if (clear) begin
      t        <= '0;
      armed    <= 1'b0;
      push_q   <= 1'b0;
      push_isi <= '0;
    end else begin
      push_q <= event_c & armed;
      if (event_c) begin
        push_isi <= t;
        t        <= CNT_W'(1);
        armed    <= 1'b1;
      end else if (ena) begin
        t <= CNT_W'(sat_inc32(32'(t), 32'(T_MAX)));
      end
    end
  end

  isi_fifo #(
    .W     (CNT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (clear),
    .push    (push_q),
    .din     (push_isi),
    .pop     (pop_c),
    .dout_c  (fifo_dout_c),
    .empty_c (fifo_empty_c),
    .drop_c  (drop_c)
  );

  assign isi.isi_data  = fifo_dout_c;
  assign isi.isi_valid = ~fifo_empty_c;

  // Sticky record of any interval lost to a full FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      overflow <= 1'b0;
    else if (clear)  overflow <= 1'b0;
    else if (drop_c) overflow <= 1'b1;
  end

  // Rate window: a shortened window_len closes the current window at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt  <= '0;
      spk_cnt  <= '0;
      rate_out <= '0;
      rate_stb <= 1'b0;
    end else begin
      rate_stb <= 1'b0;
      if (clear) begin
        win_cnt  <= '0;
        spk_cnt  <= '0;
        rate_out <= '0;
      end else if (window_len == '0) begin
        win_cnt <= '0;
        spk_cnt <= '0;
      end else if (ena) begin
        if (last_c) begin
          rate_out <= cnt_nxt_c;
          rate_stb <= 1'b1;
          win_cnt  <= '0;
          spk_cnt  <= '0;
        end else begin
          win_cnt <= win_cnt + WIN_W'(1);
          spk_cnt <= cnt_nxt_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_izh_spike_decoder.sv
// Bench for izh_spike_decoder: an interval/rate model checked every cycle,
// plus directed scenarios with hand-computed ISI and rate values.
module tb_izh_spike_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic        clear;
  logic        spike_in;
  logic [15:0] window_len;
  logic [7:0]  rate_out;
  logic        rate_stb;
  logic        overflow;

  izh_spike_decoder_if #(.CNT_W(16)) isi_if ();

  izh_spike_decoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .clear      (clear),
    .spike_in   (spike_in),
    .window_len (window_len),
    .isi        (isi_if),
    .rate_out   (rate_out),
    .rate_stb   (rate_stb),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: ISI = number of enabled cycles between rising edges, clipped to
  // 65535; it reaches the 4-entry queue one cycle after the second edge.
  int unsigned m_q[$];
  bit          m_pend, m_armed, m_spk_q, m_ovf, m_stb, m_ev;
  int unsigned m_pend_val;
  longint      m_e, m_last;
  int unsigned m_pos, m_cnt, m_rate;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_q.delete();
      m_pend = 0; m_armed = 0; m_spk_q = 0; m_ovf = 0; m_stb = 0;
      m_e = 0; m_last = 0; m_pos = 0; m_cnt = 0; m_rate = 0;
    end else begin
      m_ev  = ena && spike_in && !m_spk_q;
      m_stb = 0;
      if (clear) begin
        m_q.delete();
        m_pend = 0; m_armed = 0; m_ovf = 0; m_pos = 0; m_cnt = 0; m_rate = 0;
      end else begin
        if (isi_if.isi_ready && m_q.size() > 0) void'(m_q.pop_front());
        if (m_pend) begin
          if (m_q.size() < 4) m_q.push_back(m_pend_val);
          else m_ovf = 1;
          m_pend = 0;
        end
        if (ena) m_e++;
        if (m_ev) begin
          if (m_armed) begin
            m_pend = 1;
            m_pend_val = (m_e - m_last > 65535) ? 65535 : int'(m_e - m_last);
          end
          m_armed = 1;
          m_last  = m_e;
        end
        if (window_len == 0) begin
          m_pos = 0; m_cnt = 0;
        end else if (ena) begin
          if (m_ev) m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
          m_pos++;
          if (m_pos >= window_len) begin
            m_rate = m_cnt; m_stb = 1; m_pos = 0; m_cnt = 0;
          end
        end
      end
      m_spk_q = spike_in;
    end
  end

  // Per-cycle compare, after the edge has settled.
  always begin
    @(posedge clk);
    #2;
    check("isi_valid", isi_if.isi_valid, (m_q.size() > 0) ? 1 : 0);
    check("isi_data", isi_if.isi_data, (m_q.size() > 0) ? m_q[0] : 0);
    check("rate_out", rate_out, m_rate);
    check("rate_stb", rate_stb, m_stb);
    check("overflow", overflow, m_ovf);
  end

  // Record DUT handshakes just before each active edge.
  int unsigned isi_log[$];
  int unsigned rate_log[$];
  always begin
    @(negedge clk);
    #4;
    if (isi_if.isi_valid && isi_if.isi_ready) isi_log.push_back(isi_if.isi_data);
    if (rate_stb) rate_log.push_back(rate_out);
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle spike, next rising edge 'period' cycles later.
  task automatic pulse(input int period);
    spike_in = 1'b1;
    @(negedge clk);
    spike_in = 1'b0;
    cycles(period - 1);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic expect_log(input string nm, input int n, input int unsigned v);
    check({nm, " count"}, isi_log.size(), n);
    foreach (isi_log[i]) check({nm, " value"}, isi_log[i], v);
    isi_log.delete();
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; ena = 1'b0; clear = 1'b0; spike_in = 1'b0;
    window_len = '0; isi_if.isi_ready = 1'b0;
    @(posedge clk);
    #2;
    check("reset isi_valid", isi_if.isi_valid, 0);
    check("reset isi_data", isi_if.isi_data, 0);
    check("reset rate_out", rate_out, 0);
    check("reset rate_stb", rate_stb, 0);
    check("reset overflow", overflow, 0);
    @(negedge clk);
    rst_n = 1'b1; ena = 1'b1; isi_if.isi_ready = 1'b1;

    // Edges at 10, 30, 75: first arms, then 20 and 45.
    cycles(9);
    pulse(20); pulse(45); pulse(5);
    check("isi basic count", isi_log.size(), 2);
    if (isi_log.size() >= 2) begin
      check("isi basic first", isi_log[0], 20);
      check("isi basic second", isi_log[1], 45);
    end
    isi_log.delete();

    // Full FIFO: five ISIs, four kept, overflow sticky until clear.
    isi_if.isi_ready = 1'b0;
    do_clear();
    repeat (6) pulse(10);
    check("ovf flag", overflow, 1);
    check("ovf head", isi_if.isi_data, 10);
    isi_if.isi_ready = 1'b1;
    cycles(8);
    expect_log("ovf drain", 4, 10);
    do_clear();
    check("ovf cleared", overflow, 0);

    // Rate window of 100 with events every 10, one on each window's last cycle.
    window_len = 16'd100;
    do_clear();
    rate_log.delete();
    cycles(9);
    repeat (35) pulse(10);
    check("rate strobes", rate_log.size(), 3);
    foreach (rate_log[i]) check("rate value", rate_log[i], 10);
    check("rate_out held", rate_out, 10);
    window_len = '0;

    // Level held 50 cycles counts once; next edge 200 after the first.
    do_clear();
    isi_log.delete();
    spike_in = 1'b1;
    cycles(50);
    spike_in = 1'b0;
    cycles(150);
    pulse(5);
    expect_log("held level", 1, 200);

    // Long silence saturates the interval.
    do_clear();
    pulse(70000);
    pulse(5);
    expect_log("saturate", 1, 65535);

    // 40 disabled cycles between edges 20 enabled cycles apart.
    do_clear();
    spike_in = 1'b1;
    @(negedge clk);
    spike_in = 1'b0;
    cycles(9);
    ena = 1'b0;
    cycles(40);
    ena = 1'b1;
    cycles(10);
    pulse(5);
    expect_log("ena gap", 1, 20);

    // Asynchronous reset mid-window with data pending.
    isi_if.isi_ready = 1'b0;
    window_len = 16'd20;
    do_clear();
    repeat (3) pulse(12);
    check("pre-reset valid", isi_if.isi_valid, 1);
    check("pre-reset rate", rate_out, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("async isi_valid", isi_if.isi_valid, 0);
    check("async isi_data", isi_if.isi_data, 0);
    check("async rate_out", rate_out, 0);
    check("async rate_stb", rate_stb, 0);
    check("async overflow", overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    pulse(15);
    check("post-reset arm only", isi_if.isi_valid, 0);
    pulse(5);
    check("post-reset valid", isi_if.isi_valid, 1);
    check("post-reset isi", isi_if.isi_data, 15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/izh_spike_decoder.md
# izh_spike_decoder

Receive-side companion to the Izhikevich neuron tile: consumes the neuron's 1-bit spike output and decodes it into inter-spike intervals (ISI) and windowed spike rates. ISIs are queued in a small FIFO and drained through a valid/ready port; rates are latched once per programmable window. Sits between the neuron core's spike pin and the readout/characterisation logic on the same clock.

## Interface
- `CNT_W`, 16: ISI timer and ISI output width.
- `RATE_W`, 8: spike-count width per window.
- `WIN_W`, 16: window-length width.
- `FIFO_DEPTH`, 4: ISI FIFO entries; power of two, ≥2.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `ena`  in  1  decode enable; low freezes timers and ignores spikes.
- `clear`  in  1  synchronous flush of all state (same effect as reset except in one cycle).
- `spike_in`  in  1  neuron spike level, synchronous to `clk`.
- `window_len`  in  WIN_W  rate window in cycles; 0 disables rate output.
- `isi_data`  out  CNT_W  head-of-FIFO ISI in cycles.
- `isi_valid`  out  1  FIFO non-empty.
- `isi_ready`  in  1  consumer accepts head when `isi_valid & isi_ready`.
- `rate_out`  out  RATE_W  spike count of the last completed window.
- `rate_stb`  out  1  one-cycle pulse when `rate_out` updates.
- `overflow`  out  1  sticky: an ISI was dropped because the FIFO was full.

## Operation
- Reset values: `isi_data`=0, `isi_valid`=0, `rate_out`=0, `rate_stb`=0, `overflow`=0; internal `spike_q`=0, timer=0, armed=0, window counter=0, spike count=0.
- Event = rising edge: `spike_in`=1 and `spike_q`=0 while `ena`=1. `spike_q` samples `spike_in` every cycle regardless of `ena`; a spike held high counts once.
- ISI timer `t`: on event `t`←1; otherwise, if `ena`, `t`←min(`t`+1, 2^CNT_W−1) (saturates, no wrap).
- First event after reset/`clear` only sets armed=1; no push. Each later event pushes current `t` into the FIFO.
- Push when full: entry dropped, `overflow`←1 (held until reset/`clear`). Push and pop in the same cycle on a full FIFO: pop frees a slot, push accepted, no overflow.
- Pop on `isi_valid & isi_ready`; `isi_ready` with empty FIFO is a no-op. `isi_data` undefined-free: shows 0 when empty.
- Rate: when `ena` and `window_len`≠0, window counter counts 0..`window_len`−1. On the last cycle: `rate_out`←count including any event in that cycle, `rate_stb`=1 next cycle, count←0, window counter←0. Count saturates at 2^RATE_W−1.
- `window_len` change mid-window: takes effect immediately; if counter ≥ new `window_len`−1, window closes this cycle. `window_len`=0: counter and count held at 0, no strobes.
- `ena`=0: timer, window counter, count frozen; no events; FIFO drain still operates.
- `clear`: FIFO emptied, armed=0, `t`=0, window state 0, `overflow`=0, `rate_out`=0; takes priority over same-cycle event/pop.

## Timing
- Event at cycle N (spike_in high at N's edge sampling) → FIFO entry visible (`isi_valid`=1) after edge N+1; ISI latency 1 cycle.
- Two events with rising edges k cycles apart → pushed ISI = k (k=1 impossible for rising edges; minimum 2).
- `rate_out`/`rate_stb` registered; `rate_stb` high exactly one cycle per window.
- Consumer may hold `isi_ready` high continuously: sustains one pop per cycle.
- Reset assertion mid-operation clears all outputs asynchronously; first event after deassertion only arms.

## Structure
- Package `izh_decoder_pkg`: default width constants (`CNT_W`, `RATE_W`, `WIN_W`, `FIFO_DEPTH`) and saturating-increment function.
- Sub-module `isi_fifo`: synchronous FIFO, registered read pointer, full/empty from pointer-plus-wrap-bit, simultaneous push/pop on full allowed.
- Top holds edge detect, ISI timer, armed flag, rate window, overflow flag.

## Test plan
- Spike rising edges at cycles 10, 30, 75, `isi_ready`=1 → ISIs 20 then 45; first spike produces no entry.
- `isi_ready`=0, 6 spikes period 10 → 5 ISIs generated, FIFO holds 4×10, `overflow`=1; drain yields exactly four 10s; `clear` drops `overflow` to 0.
- `window_len`=100, spikes every 10 cycles → `rate_stb` every 100 cycles with `rate_out`=10; spike on window's last cycle counted in that window.
- Spike held high 50 cycles then low, then another edge 200 cycles after first → one ISI of 200.
- No spikes for 70000 cycles between two edges (`CNT_W`=16) → ISI 65535 (saturated).
- `ena`=0 for 40 cycles between spikes 20 cycles apart otherwise → ISI 20; `rst_n` pulsed mid-window → all outputs 0 immediately, next spike only arms.
